// File: rtl/ibex_dummy_instr_burst.sv
// ---------------------------------------------------------------------------
// ibex_dummy_instr_burst
//
// Inserts pseudo-random fake R-type instructions (rd = x0) into the IF->ID
// stream so that execution timing and power are harder to correlate with
// the real program. Insertions come in bursts of 1..2^BurstW instructions.
// An internal Galois LFSR supplies the inter-insertion count, the operands,
// the operation type and the burst length.
//
// Ports:
//   clk_i                  clock
//   rst_i                  synchronous reset, active-high (all outputs 0 while high)
//   dummy_instr_en_i       enables insertion
//   dummy_instr_mask_i     masks the top 3 bits of the insertion threshold
//   dummy_burst_mask_i     masks the LFSR burst-length field
//   dummy_instr_seed_en_i  seed-load strobe
//   dummy_instr_seed_i     seed, XORed into the LFSR state
//   fetch_valid_i          real instruction valid from IF
//   id_in_ready_i          ID stage accepts this cycle
//   insert_dummy_instr_o   dummy instruction is presented this cycle
//   dummy_instr_data_o     dummy instruction encoding (0 when not inserting)
//   dummy_burst_active_o   FSM is in INSERT (burst continuation)
//   dummy_instr_count_o    [IBEX_DUMMY_INSTR_STATS_EN only] saturating count of
//                          handshaken dummy instructions
//
// Build option: define IBEX_DUMMY_INSTR_STATS_EN to add dummy_instr_count_o.
//
// Parameter legality: CntW in 4..8, LfsrW >= CntW+13+BurstW, LfsrSeed != 0.
//
// FSM states:
//   state  | meaning
//   COUNT  | counting real fetches until cnt_q matches the LFSR threshold
//   INSERT | continuing a burst; rem_q instructions still to be handed over
// ---------------------------------------------------------------------------
module ibex_dummy_instr_burst #(
    parameter int unsigned          CntW     = 5,
    parameter int unsigned          BurstW   = 2,
    parameter int unsigned          LfsrW    = 32,
    parameter logic [LfsrW-1:0]     LfsrTaps = 32'h8000_0057,
    parameter logic [LfsrW-1:0]     LfsrSeed = 32'hACE1_2468,
    parameter bit                   AllowDiv = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dummy_instr_en_i,
    input  logic [2:0]        dummy_instr_mask_i,
    input  logic [BurstW-1:0] dummy_burst_mask_i,
    input  logic              dummy_instr_seed_en_i,
    input  logic [LfsrW-1:0]  dummy_instr_seed_i,
    input  logic              fetch_valid_i,
    input  logic              id_in_ready_i,
    output logic              insert_dummy_instr_o,
    output logic [31:0]       dummy_instr_data_o,
`ifdef IBEX_DUMMY_INSTR_STATS_EN
    output logic [15:0]       dummy_instr_count_o,
`endif
    output logic              dummy_burst_active_o
);

    // LFSR field positions, LSB first: cnt, op_a, op_b, type, burst
    localparam int unsigned OpALsb  = CntW;
    localparam int unsigned OpBLsb  = CntW + 5;
    localparam int unsigned TypeLsb = CntW + 10;
    localparam int unsigned BurstLsb = CntW + 13;

    typedef enum logic {
        COUNT  = 1'b0,
        INSERT = 1'b1
    } state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [BurstW-1:0]  rem_q;
    logic [LfsrW-1:0]   lfsr_q;

    logic [CntW-1:0]    lfsr_cnt;
    logic [CntW-1:0]    thr;
    logic [4:0]         op_a;
    logic [4:0]         op_b;
    logic [2:0]         itype;
    logic [BurstW-1:0]  burst_fld;
    logic [BurstW-1:0]  burst_extra;
    logic [LfsrW-1:0]   lfsr_step;
    logic [LfsrW-1:0]   lfsr_seeded;
    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic               insert;
    logic               hs;
    logic               count_en;

    // -----------------------------------------------------------------------
    // LFSR field extraction
    // -----------------------------------------------------------------------
    assign lfsr_cnt  = lfsr_q[CntW-1:0];
    assign op_a      = lfsr_q[OpALsb +: 5];
    assign op_b      = lfsr_q[OpBLsb +: 5];
    assign itype     = lfsr_q[TypeLsb +: 3];
    assign burst_fld = lfsr_q[BurstLsb +: BurstW];

    // Only the top 3 threshold bits are maskable; the low bits always pass.
    assign thr = lfsr_cnt & {dummy_instr_mask_i, {(CntW-3){1'b1}}};

    // Burst length minus one; zero means a single-instruction burst.
    assign burst_extra = burst_fld & dummy_burst_mask_i;

    assign lfsr_step   = (lfsr_q >> 1) ^ (LfsrTaps & {LfsrW{lfsr_q[0]}});
    assign lfsr_seeded = lfsr_q ^ dummy_instr_seed_i;

    // -----------------------------------------------------------------------
    // Insert decision and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        insert = 1'b0;
        if (!rst_i && dummy_instr_en_i) begin
            if (state_q == INSERT) begin
                insert = 1'b1;
            end else begin
                insert = (cnt_q == thr);
            end
        end
    end

    assign hs       = insert & id_in_ready_i;
    assign count_en = dummy_instr_en_i & id_in_ready_i & fetch_valid_i & ~insert;

    // -----------------------------------------------------------------------
    // Instruction encoding
    // -----------------------------------------------------------------------
    always_comb begin
        funct7 = 7'h00;
        funct3 = 3'd0;
        unique case (itype)
            3'd0: begin funct7 = 7'h00; funct3 = 3'd0; end    // ADD
            3'd1: begin funct7 = 7'h01; funct3 = 3'd0; end    // MUL
            3'd2: begin                                       // DIV
                if (AllowDiv) begin
                    funct7 = 7'h01; funct3 = 3'd4;
                end else begin
                    funct7 = 7'h00; funct3 = 3'd0;            // as ADD
                end
            end
            3'd3: begin funct7 = 7'h00; funct3 = 3'd7; end    // AND
            3'd4: begin funct7 = 7'h20; funct3 = 3'd0; end    // SUB
            3'd5: begin funct7 = 7'h00; funct3 = 3'd4; end    // XOR
            3'd6: begin funct7 = 7'h00; funct3 = 3'd6; end    // OR
            3'd7: begin                                       // REM
                if (AllowDiv) begin
                    funct7 = 7'h01; funct3 = 3'd6;
                end else begin
                    funct7 = 7'h00; funct3 = 3'd7;            // as AND
                end
            end
            default: begin funct7 = 7'h00; funct3 = 3'd0; end
        endcase
    end

    assign insert_dummy_instr_o = insert;
    assign dummy_instr_data_o   = insert ? {funct7, op_b, op_a, funct3, 5'h00, 7'h33}
                                         : 32'h0000_0000;
    assign dummy_burst_active_o = ~rst_i & (state_q == INSERT);

    // -----------------------------------------------------------------------
    // LFSR: a seed load wins over a step; an all-zero result would lock up,
    // so it falls back to the reset seed.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
        end else if (dummy_instr_seed_en_i) begin
            lfsr_q <= (lfsr_seeded == '0) ? LfsrSeed : lfsr_seeded;
        end else if (hs) begin
            lfsr_q <= lfsr_step;
        end
    end

    // -----------------------------------------------------------------------
    // Insertion FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= COUNT;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                COUNT: begin
                    if (hs) begin
                        cnt_q <= '0;
                        // burst length comes from the LFSR value being handed over
                        if (burst_extra != '0) begin
                            rem_q   <= burst_extra;
                            state_q <= INSERT;
                        end
                    end else if (count_en) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                INSERT: begin
                    cnt_q <= '0;
                    if (!dummy_instr_en_i) begin
                        // disabling mid-burst abandons the rest of the burst
                        rem_q   <= '0;
                        state_q <= COUNT;
                    end else if (hs) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == BurstW'(1)) begin
                            state_q <= COUNT;
                        end
                    end
                end
                default: begin
                    state_q <= COUNT;
                    cnt_q   <= '0;
                    rem_q   <= '0;
                end
            endcase
        end
    end

`ifdef IBEX_DUMMY_INSTR_STATS_EN
    // -----------------------------------------------------------------------
    // Handshake statistics; a reseed starts a fresh measurement window.
    // -----------------------------------------------------------------------
    logic [15:0] stat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || dummy_instr_seed_en_i) begin
            stat_q <= '0;
        end else if (hs && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign dummy_instr_count_o = rst_i ? 16'h0000 : stat_q;
`endif

endmodule

// File: tb/tb_ibex_dummy_instr_burst.sv
module tb_ibex_dummy_instr_burst;

    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] TAPS = 32'h8000_0057;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  mask;
    logic [1:0]  bmask;
    logic        seed_en;
    logic [31:0] seed;
    logic        fv;
    logic        ready;
    logic        ins;
    logic [31:0] data;
    logic        bact;

    logic        en2;
    logic        seed_en2;
    logic [31:0] seed2;
    logic        ins2;
    logic [31:0] data2;
    logic        bact2;
`ifdef IBEX_DUMMY_INSTR_STATS_EN
    logic [15:0] cnt_o;
    logic [15:0] cnt_o2;
`endif

    int checks   = 0;
    int failures = 0;

    // behavioural reference state
    bit [31:0] m_lfsr  = SEED;
    bit [4:0]  m_cnt   = '0;
    bit [1:0]  m_rem   = '0;
    bit        m_burst = 1'b0;
    bit [15:0] m_count = '0;

    ibex_dummy_instr_burst dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .dummy_instr_en_i      (en),
        .dummy_instr_mask_i    (mask),
        .dummy_burst_mask_i    (bmask),
        .dummy_instr_seed_en_i (seed_en),
        .dummy_instr_seed_i    (seed),
        .fetch_valid_i         (fv),
        .id_in_ready_i         (ready),
        .insert_dummy_instr_o  (ins),
        .dummy_instr_data_o    (data),
`ifdef IBEX_DUMMY_INSTR_STATS_EN
        .dummy_instr_count_o   (cnt_o),
`endif
        .dummy_burst_active_o  (bact)
    );

    ibex_dummy_instr_burst #(.AllowDiv(1'b0)) dut_nodiv (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .dummy_instr_en_i      (en2),
        .dummy_instr_mask_i    (mask),
        .dummy_burst_mask_i    (bmask),
        .dummy_instr_seed_en_i (seed_en2),
        .dummy_instr_seed_i    (seed2),
        .fetch_valid_i         (fv),
        .id_in_ready_i         (ready),
        .insert_dummy_instr_o  (ins2),
        .dummy_instr_data_o    (data2),
`ifdef IBEX_DUMMY_INSTR_STATS_EN
        .dummy_instr_count_o   (cnt_o2),
`endif
        .dummy_burst_active_o  (bact2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit [31:0] lstep(input bit [31:0] l);
        return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
    endfunction

    function automatic bit [31:0] enc(input bit [31:0] l, input bit allow_div);
        bit [2:0] t;
        bit [6:0] f7;
        bit [2:0] f3;
        t = l[17:15];
        if (!allow_div && t == 3'd2) t = 3'd0;
        if (!allow_div && t == 3'd7) t = 3'd3;
        case (t)
            3'd0:    begin f7 = 7'h00; f3 = 3'd0; end
            3'd1:    begin f7 = 7'h01; f3 = 3'd0; end
            3'd2:    begin f7 = 7'h01; f3 = 3'd4; end
            3'd3:    begin f7 = 7'h00; f3 = 3'd7; end
            3'd4:    begin f7 = 7'h20; f3 = 3'd0; end
            3'd5:    begin f7 = 7'h00; f3 = 3'd4; end
            3'd6:    begin f7 = 7'h00; f3 = 3'd6; end
            default: begin f7 = 7'h01; f3 = 3'd6; end
        endcase
        return {f7, l[14:10], l[9:5], f3, 5'h00, 7'h33};
    endfunction

    function automatic bit model_ins();
        if (rst || !en) return 1'b0;
        if (m_burst) return 1'b1;
        return m_cnt == (m_lfsr[4:0] & {mask, 2'b11});
    endfunction

    task automatic model_update();
        bit        e_ins;
        bit        hs;
        bit [31:0] x;
        e_ins = model_ins();
        hs    = e_ins && ready;
        if (rst) begin
            m_lfsr = SEED; m_cnt = '0; m_rem = '0; m_burst = 1'b0; m_count = '0;
        end else begin
            if (m_burst) begin
                if (!en) begin
                    m_burst = 1'b0; m_cnt = '0; m_rem = '0;
                end else if (hs) begin
                    m_rem = m_rem - 2'd1;
                    if (m_rem == 2'd0) m_burst = 1'b0;
                end
            end else begin
                if (hs) begin
                    m_cnt = '0;
                    m_rem = m_lfsr[19:18] & bmask;
                    if (m_rem != 2'd0) m_burst = 1'b1;
                end else if (en && ready && fv) begin
                    m_cnt = m_cnt + 5'd1;
                end
            end
            if (seed_en) m_count = '0;
            else if (hs && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (seed_en) begin
                x = m_lfsr ^ seed;
                m_lfsr = (x == 32'h0) ? SEED : x;
            end else if (hs) begin
                m_lfsr = lstep(m_lfsr);
            end
        end
    endtask

    task automatic adv();
        model_update();
        @(negedge clk);
    endtask

    task automatic seed_to(input bit [31:0] target);
        en = 1'b0; seed_en = 1'b1; seed = m_lfsr ^ target;
        #1;
        adv();
        seed_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; ready = 1'b1; fv = 1'b1;
        #1;
        if (ins !== 1'b0) begin failures++; $display("FAIL reset_ins got=%b exp=0", ins); end
        checks++;
        if (data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++;
        if (bact !== 1'b0) begin failures++; $display("FAIL reset_bact got=%b exp=0", bact); end
        checks++;
        adv(); adv();
        rst = 1'b0; en = 1'b0; fv = 1'b0;
        #1;
        if (dut.lfsr_q !== SEED) begin failures++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_q, SEED); end
        checks++;
        if (dut.cnt_q !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_q); end
        checks++;
    endtask

    task automatic test_count_threshold();
        mask = 3'b000; bmask = 2'b00; ready = 1'b1; fv = 1'b0;
        seed_to(32'h0000_0003);
        en = 1'b1;
        #1;
        if (ins !== 1'b0) begin failures++; $display("FAIL thr_idle_ins got=%b exp=0", ins); end
        checks++;
        adv();
        fv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ins !== 1'b0) begin failures++; $display("FAIL thr_early_ins cyc=%0d got=%b exp=0", i, ins); end
            checks++;
            adv();
        end
        #1;
        if (ins !== 1'b1) begin failures++; $display("FAIL thr_ins got=%b exp=1", ins); end
        checks++;
        if (data !== 32'h0000_0033) begin failures++; $display("FAIL thr_data got=%h exp=00000033", data); end
        checks++;
        adv();
        en = 1'b0; fv = 1'b0;
        #1;
        if (dut.cnt_q !== 5'd0) begin failures++; $display("FAIL thr_cnt_clr got=%0d exp=0", dut.cnt_q); end
        checks++;
    endtask

    task automatic test_mul_encoding();
        ready = 1'b0;
        seed_to(32'h0000_9CA0);
        en = 1'b1;
        #1;
        if (ins !== 1'b1) begin failures++; $display("FAIL mul_ins got=%b exp=1", ins); end
        checks++;
        if (data !== 32'h0272_8033) begin failures++; $display("FAIL mul_data got=%h exp=02728033", data); end
        checks++;
        adv();
        en = 1'b0;
    endtask

    task automatic test_burst();
        bit [31:0] exp_l;
        mask = 3'b000; fv = 1'b0;
        // 4-instruction burst
        ready = 1'b1; bmask = 2'b11;
        seed_to(32'h000C_0000);
        en = 1'b1;
        exp_l = 32'h000C_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ins !== 1'b1) begin failures++; $display("FAIL burst4_ins i=%0d got=%b exp=1", i, ins); end
            checks++;
            if (bact !== (i > 0)) begin failures++; $display("FAIL burst4_bact i=%0d got=%b exp=%b", i, bact, (i > 0)); end
            checks++;
            if (data !== enc(exp_l, 1'b1)) begin failures++; $display("FAIL burst4_data i=%0d got=%h exp=%h", i, data, enc(exp_l, 1'b1)); end
            checks++;
            exp_l = lstep(exp_l);
            adv();
        end
        en = 1'b0;
        #1;
        if (bact !== 1'b0) begin failures++; $display("FAIL burst4_end_bact got=%b exp=0", bact); end
        checks++;
        if (dut.lfsr_q !== exp_l) begin failures++; $display("FAIL burst4_lfsr got=%h exp=%h", dut.lfsr_q, exp_l); end
        checks++;
        // same field, narrower mask: 2-instruction burst
        bmask = 2'b01;
        seed_to(32'h000C_0000);
        en = 1'b1;
        exp_l = 32'h000C_0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (ins !== 1'b1) begin failures++; $display("FAIL burst2_ins i=%0d got=%b exp=1", i, ins); end
            checks++;
            if (bact !== (i > 0)) begin failures++; $display("FAIL burst2_bact i=%0d got=%b exp=%b", i, bact, (i > 0)); end
            checks++;
            exp_l = lstep(exp_l);
            adv();
        end
        en = 1'b0;
        #1;
        if (bact !== 1'b0) begin failures++; $display("FAIL burst2_end_bact got=%b exp=0", bact); end
        checks++;
        if (dut.lfsr_q !== exp_l) begin failures++; $display("FAIL burst2_lfsr got=%h exp=%h", dut.lfsr_q, exp_l); end
        checks++;
    endtask

    task automatic test_stall();
        bmask = 2'b00; mask = 3'b000; fv = 1'b1; ready = 1'b0;
        seed_to(32'h0000_9CA0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ins !== 1'b1) begin failures++; $display("FAIL stall_ins i=%0d got=%b exp=1", i, ins); end
            checks++;
            if (data !== 32'h0272_8033) begin failures++; $display("FAIL stall_data i=%0d got=%h exp=02728033", i, data); end
            checks++;
            if (dut.lfsr_q !== 32'h0000_9CA0) begin failures++; $display("FAIL stall_lfsr i=%0d got=%h exp=00009ca0", i, dut.lfsr_q); end
            checks++;
            if (dut.cnt_q !== 5'd0) begin failures++; $display("FAIL stall_cnt i=%0d got=%0d exp=0", i, dut.cnt_q); end
            checks++;
            adv();
        end
        ready = 1'b1;
        #1;
        adv();
        en = 1'b0; fv = 1'b0;
        #1;
        if (dut.lfsr_q !== 32'h0000_4E50) begin failures++; $display("FAIL stall_step got=%h exp=00004e50", dut.lfsr_q); end
        checks++;
    endtask

    task automatic test_abort();
        mask = 3'b000; bmask = 2'b11; ready = 1'b1; fv = 1'b0;
        seed_to(32'h000C_0000);
        en = 1'b1;
        #1;
        adv();
        #1;
        if (bact !== 1'b1) begin failures++; $display("FAIL abort_bact_pre got=%b exp=1", bact); end
        checks++;
        en = 1'b0;
        #1;
        if (ins !== 1'b0) begin failures++; $display("FAIL abort_ins got=%b exp=0", ins); end
        checks++;
        adv();
        #1;
        if (bact !== 1'b0) begin failures++; $display("FAIL abort_bact got=%b exp=0", bact); end
        checks++;
        if (dut.cnt_q !== 5'd0) begin failures++; $display("FAIL abort_cnt got=%0d exp=0", dut.cnt_q); end
        checks++;
        if (dut.rem_q !== 2'd0) begin failures++; $display("FAIL abort_rem got=%0d exp=0", dut.rem_q); end
        checks++;
        // reset in the middle of a burst
        seed_to(32'h000C_0000);
        en = 1'b1;
        #1;
        adv();
        rst = 1'b1;
        #1;
        if (ins !== 1'b0) begin failures++; $display("FAIL rstmid_ins got=%b exp=0", ins); end
        checks++;
        if (data !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", data); end
        checks++;
        if (bact !== 1'b0) begin failures++; $display("FAIL rstmid_bact got=%b exp=0", bact); end
        checks++;
        adv();
        rst = 1'b0; en = 1'b0;
        #1;
        if (dut.lfsr_q !== SEED) begin failures++; $display("FAIL rstmid_lfsr got=%h exp=%h", dut.lfsr_q, SEED); end
        checks++;
        if (dut.cnt_q !== 5'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", dut.cnt_q); end
        checks++;
    endtask

    task automatic test_nodiv();
        rst = 1'b1; en = 1'b0; en2 = 1'b0; ready = 1'b0; fv = 1'b0;
        #1;
        adv();
        rst = 1'b0;
        // DIV field with op_a=1, op_b=2
        seed_en2 = 1'b1; seed2 = SEED ^ 32'h0001_0820;
        #1;
        adv();
        seed_en2 = 1'b0; en2 = 1'b1;
        #1;
        if (ins2 !== 1'b1) begin failures++; $display("FAIL nodiv_div_ins got=%b exp=1", ins2); end
        checks++;
        if (data2 !== 32'h0020_8033) begin failures++; $display("FAIL nodiv_div_data got=%h exp=00208033", data2); end
        checks++;
        if (bact2 !== 1'b0) begin failures++; $display("FAIL nodiv_bact got=%b exp=0", bact2); end
        checks++;
        adv();
        // REM field, zero operands
        en2 = 1'b0; seed_en2 = 1'b1; seed2 = 32'h0001_0820 ^ 32'h0003_8000;
        #1;
        adv();
        seed_en2 = 1'b0; en2 = 1'b1;
        #1;
        if (data2 !== 32'h0000_7033) begin failures++; $display("FAIL nodiv_rem_data got=%h exp=00007033", data2); end
        checks++;
`ifdef IBEX_DUMMY_INSTR_STATS_EN
        if (cnt_o2 !== 16'd0) begin failures++; $display("FAIL nodiv_count got=%0d exp=0", cnt_o2); end
        checks++;
`endif
        adv();
        en2 = 1'b0;
    endtask

`ifdef IBEX_DUMMY_INSTR_STATS_EN
    task automatic test_stats();
        mask = 3'b000; bmask = 2'b10; ready = 1'b1; fv = 1'b0;
        seed_to(32'h000C_0000);
        #1;
        if (cnt_o !== 16'd0) begin failures++; $display("FAIL stats_clr0 got=%0d exp=0", cnt_o); end
        checks++;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            adv();
        end
        en = 1'b0;
        #1;
        if (cnt_o !== 16'd3) begin failures++; $display("FAIL stats_three got=%0d exp=3", cnt_o); end
        checks++;
        seed_to(32'h1234_5678);
        #1;
        if (cnt_o !== 16'd0) begin failures++; $display("FAIL stats_seedclr got=%0d exp=0", cnt_o); end
        checks++;
    endtask
`endif

    task automatic test_random();
        bit        e_ins;
        bit [31:0] e_data;
        bit        e_bact;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 9) < 8);
            fv      = ($urandom_range(0, 1) == 1);
            ready   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) mask  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) bmask = 2'($urandom_range(0, 3));
            seed_en = ($urandom_range(0, 49) == 0);
            seed    = ($urandom_range(0, 3) == 0) ? m_lfsr : $urandom;
            #1;
            e_ins  = model_ins();
            e_data = e_ins ? enc(m_lfsr, 1'b1) : 32'h0;
            e_bact = !rst && m_burst;
            if (ins !== e_ins) begin failures++; $display("FAIL rnd_ins cyc=%0d got=%b exp=%b", i, ins, e_ins); end
            checks++;
            if (data !== e_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, data, e_data); end
            checks++;
            if (bact !== e_bact) begin failures++; $display("FAIL rnd_bact cyc=%0d got=%b exp=%b", i, bact, e_bact); end
            checks++;
`ifdef IBEX_DUMMY_INSTR_STATS_EN
            if (cnt_o !== (rst ? 16'd0 : m_count)) begin
                failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, cnt_o, (rst ? 16'd0 : m_count));
            end
            checks++;
`endif
            adv();
        end
        rst = 1'b0; en = 1'b0; seed_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mask = 3'b000; bmask = 2'b00;
        seed_en = 1'b0; seed = 32'h0; fv = 1'b0; ready = 1'b0;
        en2 = 1'b0; seed_en2 = 1'b0; seed2 = 32'h0;
        @(negedge clk);
        test_reset();
        test_count_threshold();
        test_mul_encoding();
        test_burst();
        test_stall();
        test_abort();
        test_nodiv();
`ifdef IBEX_DUMMY_INSTR_STATS_EN
        test_stats();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
